// File: rtl/cart_eeprom_ctrl.sv
// Serial EEPROM port of the cartridge mapper.
// Register file at I/O C4h-C8h drives 93C46-class Microwire frames on the EE_* pins.
// Valid/ready contract: a register write is accepted only on a CLK edge where
// SEL & WR_STB are high and the block is ready (FSM idle); otherwise it is
// dropped. A go write drops ready on that same edge, and ready stays low until
// the frame has fully completed.
module cart_eeprom_ctrl #(
    parameter int SK_DIV    = 4,
    parameter int ADDR_BITS = 6,
    parameter int POLL_MAX  = 4096
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       SEL,
    input  logic       WR_STB,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       EE_CS,
    output logic       EE_SK,
    output logic       EE_DI,
    input  logic       EE_DO
);

    localparam int CMD_BITS = ADDR_BITS + 3;
    localparam int DIV_W    = $clog2(SK_DIV + 1);
    localparam int POLL_W   = $clog2(POLL_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_DIN   = 3'd3;
    localparam logic [2:0] S_DOUT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_POLL  = 3'd6;
    localparam logic [2:0] S_END   = 3'd7;

    localparam logic [1:0] K_READ  = 2'd0;
    localparam logic [1:0] K_WRITE = 2'd1;
    localparam logic [1:0] K_SHORT = 2'd2;

    logic [2:0]          state;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [15:0]         data_q;
    logic [15:0]         cmd_q;
    logic [15:0]         dsr;
    logic [CMD_BITS-1:0] csr;
    logic [4:0]          bit_cnt;
    logic                hp;
    logic [POLL_W-1:0]   poll_cnt;
    logic [1:0]          kind;
    logic                wait_q;
    logic                ready_q;
    logic                done_q;
    logic                err_q;
    logic                wr_ok;
    logic                go;

    assign wr_ok = SEL && WR_STB && ready_q;
    assign go    = wr_ok && (ADDR == 8'hC8) && (WDATA[4] || WDATA[5] || WDATA[6]);
    assign tick  = (state != S_IDLE) && (div_cnt == DIV_W'(SK_DIV - 1));

    // Half-period divider: held at zero while idle so every frame starts aligned.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Register file writes and the Microwire frame sequencer.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            data_q   <= '0;
            cmd_q    <= '0;
            dsr      <= '0;
            csr      <= '0;
            bit_cnt  <= '0;
            hp       <= 1'b0;
            poll_cnt <= '0;
            kind     <= K_READ;
            wait_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            EE_CS    <= 1'b0;
            EE_SK    <= 1'b0;
            EE_DI    <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (ADDR)
                    8'hC4:   data_q[7:0]  <= WDATA;
                    8'hC5:   data_q[15:8] <= WDATA;
                    8'hC6:   cmd_q[7:0]   <= WDATA;
                    8'hC7:   cmd_q[15:8]  <= WDATA;
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state   <= S_SETUP;
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        EE_CS   <= 1'b1;
                        EE_SK   <= 1'b0;
                        EE_DI   <= 1'b0;
                        csr     <= {1'b1, cmd_q[ADDR_BITS+1:0]};
                        dsr     <= data_q;
                        kind    <= WDATA[4] ? K_READ : (WDATA[5] ? K_WRITE : K_SHORT);
                        wait_q  <= WDATA[7] && !WDATA[4] && !WDATA[5];
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        state   <= S_CMD;
                        hp      <= 1'b0;
                        bit_cnt <= '0;
                        EE_DI   <= csr[CMD_BITS-1];
                        csr     <= {csr[CMD_BITS-2:0], 1'b0};
                    end
                end
                S_CMD: begin
                    if (tick) begin
                        hp    <= !hp;
                        EE_SK <= !hp;
                        if (hp) begin
                            if (bit_cnt == 5'(CMD_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (kind == K_READ) begin
                                    state <= S_DOUT;
                                    EE_DI <= 1'b0;
                                end else if (kind == K_WRITE) begin
                                    state <= S_DIN;
                                    EE_DI <= dsr[15];
                                    dsr   <= {dsr[14:0], 1'b0};
                                end else begin
                                    state <= wait_q ? S_GAP : S_END;
                                    EE_CS <= 1'b0;
                                    EE_DI <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                EE_DI   <= csr[CMD_BITS-1];
                                csr     <= {csr[CMD_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_DIN: begin
                    if (tick) begin
                        hp    <= !hp;
                        EE_SK <= !hp;
                        if (hp) begin
                            if (bit_cnt == 5'd15) begin
                                state <= S_GAP;
                                EE_CS <= 1'b0;
                                EE_DI <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                EE_DI   <= dsr[15];
                                dsr     <= {dsr[14:0], 1'b0};
                            end
                        end
                    end
                end
                S_DOUT: begin
                    if (tick) begin
                        hp    <= !hp;
                        EE_SK <= !hp;
                        if (hp) begin
                            // Sample at the falling SK edge that closes the slot.
                            data_q <= {data_q[14:0], EE_DO};
                            if (bit_cnt == 5'd15) begin
                                state <= S_END;
                                EE_CS <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        state    <= S_POLL;
                        EE_CS    <= 1'b1;
                        poll_cnt <= '0;
                    end
                end
                S_POLL: begin
                    if (tick) begin
                        if (EE_DO) begin
                            state <= S_END;
                            EE_CS <= 1'b0;
                        end else if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                            state <= S_END;
                            EE_CS <= 1'b0;
                            err_q <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    EE_CS   <= 1'b0;
                    EE_SK   <= 1'b0;
                    EE_DI   <= 1'b0;
                end
            endcase
        end
    end

    // Register readback, combinational from ADDR.
    always_comb begin
        RDATA = 8'h00;
        case (ADDR)
            8'hC4:   RDATA = data_q[7:0];
            8'hC5:   RDATA = data_q[15:8];
            8'hC6:   RDATA = cmd_q[7:0];
            8'hC7:   RDATA = cmd_q[15:8];
            8'hC8:   RDATA = {err_q, 5'b0, done_q, ready_q};
            default: RDATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cart_eeprom_ctrl.sv
// Bench for cart_eeprom_ctrl: a frame-level model predicts the EE pin waveform
// per CLK, a small EEPROM responder drives EE_DO and logs DI bits at SK rises.
module tb_cart_eeprom_ctrl;

    localparam int SK_DIV    = 4;
    localparam int ADDR_BITS = 6;
    localparam int POLL_MAX  = 48;

    logic       CLK    = 1'b0;
    logic       RSTn   = 1'b0;
    logic       SEL    = 1'b0;
    logic       WR_STB = 1'b0;
    logic [7:0] ADDR   = 8'hC8;
    logic [7:0] WDATA  = 8'h00;
    logic [7:0] RDATA;
    logic       EE_CS, EE_SK, EE_DI;
    logic       EE_DO  = 1'b0;

    cart_eeprom_ctrl #(.SK_DIV(SK_DIV), .ADDR_BITS(ADDR_BITS), .POLL_MAX(POLL_MAX)) dut (
        .CLK(CLK), .RSTn(RSTn), .SEL(SEL), .WR_STB(WR_STB), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .EE_CS(EE_CS), .EE_SK(EE_SK),
        .EE_DI(EE_DI), .EE_DO(EE_DO)
    );

    // Clock and cycle counter
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int shown = 0;
    int go_cyc = 0;
    logic [2:0] exp_q[$];

    // EEPROM responder state
    int         mode = 0;          // 0: serve a READ, 1: busy/ready poll
    logic [15:0] rd_val = 16'h0;
    int         busy_cyc = 0;
    int         rises = 0;
    int         cs_cnt = 0;
    logic       pcs = 1'b0, psk = 1'b0;
    logic       di_log[$];

    // Per-cycle pin compare against the model queue (idle pins are all zero)
    always @(negedge CLK) begin
        logic [2:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        total++;
        if ({EE_CS, EE_SK, EE_DI} !== e) begin
            bad++;
            if (shown < 20) begin
                shown++;
                $display("FAIL pins cyc=%0d got cs/sk/di=%b want=%b", cyc, {EE_CS, EE_SK, EE_DI}, e);
            end
        end
    end

    // EEPROM responder: logs DI at SK rise, drives data bits or ready/busy
    always @(negedge CLK) begin
        if (EE_CS && !pcs) begin
            rises  = 0;
            cs_cnt = 0;
            if (mode == 0) EE_DO = 1'b1;
        end
        if (EE_CS) begin
            cs_cnt++;
            if (EE_SK && !psk) begin
                di_log.push_back(EE_DI);
                rises++;
                if (mode == 0 && rises >= 10 && rises <= 25) EE_DO = rd_val[25 - rises];
            end
            if (mode == 1) EE_DO = (cs_cnt >= busy_cyc);
        end
        pcs = EE_CS;
        psk = EE_SK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Model: expected {cs,sk,di} per CLK after the go edge
    task automatic push_hp(input logic cs, input logic sk, input logic di);
        for (int i = 0; i < SK_DIV; i++) exp_q.push_back({cs, sk, di});
    endtask

    task automatic push_bit(input logic b);
        push_hp(1'b1, 1'b0, b);
        push_hp(1'b1, 1'b1, b);
    endtask

    task automatic model_frame(input int kind, input logic [15:0] cmd, input logic [15:0] data,
                               input bit wt, input int poll_hp, output int len);
        logic [ADDR_BITS+2:0] c;
        c = {1'b1, cmd[ADDR_BITS+1:0]};
        push_hp(1'b1, 1'b0, 1'b0);
        for (int i = ADDR_BITS + 2; i >= 0; i--) push_bit(c[i]);
        if (kind == 0) for (int i = 0; i < 16; i++) push_bit(1'b0);
        if (kind == 1) for (int i = 15; i >= 0; i--) push_bit(data[i]);
        if (kind == 1 || (kind == 2 && wt)) begin
            push_hp(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < poll_hp; i++) push_hp(1'b1, 1'b0, 1'b0);
        end
        exp_q.push_back(3'b000);
        len = exp_q.size();
    endtask

    // Driver tasks
    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d, input logic sel);
        @(negedge CLK);
        SEL = sel; WR_STB = 1'b1; ADDR = a; WDATA = d;
        @(posedge CLK);
        #1;
        WR_STB = 1'b0; SEL = 1'b0; ADDR = 8'hC8;
    endtask

    task automatic go_frame(input logic [7:0] d, input int kind, input logic [15:0] cmd,
                            input logic [15:0] data, input bit wt, input int poll_hp, output int len);
        di_log.delete();
        reg_wr(8'hC8, d, 1'b1);
        go_cyc = cyc;
        model_frame(kind, cmd, data, wt, poll_hp, len);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        @(negedge CLK);
        ADDR = a;
        #1;
        v = RDATA;
        ADDR = 8'hC8;
    endtask

    task automatic wait_ready(input string name, input int len);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge CLK);
            if (RDATA[0] === 1'b1) break;
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout got=no_ready want=ready", name);
        end else begin
            check({name, "_latency"}, cyc - go_cyc, len);
        end
    endtask

    task automatic check_di(input string name, input logic [24:0] want);
        logic [24:0] got;
        got = '0;
        foreach (di_log[i]) got = {got[23:0], di_log[i]};
        check({name, "_di_count"}, di_log.size(), 25);
        check({name, "_di_bits"}, got, want);
    endtask

    initial begin
        logic [7:0] v;
        int len;

        // Reset state
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        rd(8'hC8, v); check("rst_stat", v, 8'h01);
        rd(8'hC4, v); check("rst_data_lo", v, 8'h00);
        rd(8'hC7, v); check("rst_cmd_hi", v, 8'h00);
        rd(8'hC9, v); check("unmapped", v, 8'h00);

        // READ: CMD=85h, EEPROM returns 1234h
        mode = 0; rd_val = 16'h1234;
        reg_wr(8'hC6, 8'h85, 1'b1);
        reg_wr(8'hC7, 8'h00, 1'b1);
        rd(8'hC6, v); check("cmd_lo_rb", v, 8'h85);
        go_frame(8'h10, 0, 16'h0085, 16'h0, 1'b0, 0, len);
        check("read_len_model", len, 205);
        wait_ready("read", len);
        rd(8'hC8, v); check("read_stat", v, 8'h03);
        rd(8'hC4, v); check("read_lo", v, 8'h34);
        rd(8'hC5, v); check("read_hi", v, 8'h12);
        check_di("read", {9'b1_10_000101, 16'h0000});

        // WRITE: DATA=A55Ah, CMD=45h, busy 40 half-periods
        mode = 1; busy_cyc = 40 * SK_DIV;
        reg_wr(8'hC4, 8'h5A, 1'b1);
        reg_wr(8'hC5, 8'hA5, 1'b1);
        reg_wr(8'hC6, 8'h45, 1'b1);
        go_frame(8'h20, 1, 16'h0045, 16'hA55A, 1'b0, 40, len);
        check("write_len_model", len, 369);
        wait_ready("write", len);
        rd(8'hC8, v); check("write_stat", v, 8'h03);
        rd(8'hC5, v); check("write_data_kept", v, 8'hA5);
        check_di("write", {9'b1_01_000101, 16'hA55A});

        // Timeout: SHORT+WAIT with EE_DO stuck low
        busy_cyc = 1000000;
        go_frame(8'hC0, 2, 16'h0045, 16'h0, 1'b1, POLL_MAX, len);
        check("tmo_len_model", len, 273);
        wait_ready("tmo", len);
        rd(8'hC8, v); check("tmo_stat", v, 8'h83);
        go_frame(8'h40, 2, 16'h0045, 16'h0, 1'b0, 0, len);
        check("short_len_model", len, 77);
        wait_ready("short", len);
        rd(8'hC8, v); check("err_cleared", v, 8'h03);

        // Busy lockout: writes during a READ are dropped
        mode = 0; rd_val = 16'hBEEF;
        go_frame(8'h10, 0, 16'h0045, 16'h0, 1'b0, 0, len);
        repeat (10) @(posedge CLK);
        reg_wr(8'hC4, 8'hFF, 1'b1);
        reg_wr(8'hC8, 8'h10, 1'b1);
        wait_ready("lock", len);
        repeat (30) @(posedge CLK);
        rd(8'hC8, v); check("lock_stat", v, 8'h03);
        rd(8'hC4, v); check("lock_lo", v, 8'hEF);
        rd(8'hC5, v); check("lock_hi", v, 8'hBE);

        // Priority: READ and WRITE go together -> READ frame
        rd_val = 16'h5AC3;
        go_frame(8'h30, 0, 16'h0045, 16'h0, 1'b0, 0, len);
        wait_ready("prio", len);
        rd(8'hC4, v); check("prio_lo", v, 8'hC3);
        rd(8'hC5, v); check("prio_hi", v, 8'h5A);

        // SEL low: no frame, ready stays set
        reg_wr(8'hC8, 8'h10, 1'b0);
        reg_wr(8'hC4, 8'h77, 1'b0);
        repeat (20) @(posedge CLK);
        rd(8'hC8, v); check("nosel_stat", v, 8'h03);
        rd(8'hC4, v); check("nosel_data", v, 8'hC3);

        // Reset asserted mid-WRITE frame
        mode = 1; busy_cyc = 40 * SK_DIV;
        go_frame(8'h20, 1, 16'h0045, 16'h5AC3, 1'b0, 40, len);
        repeat (100) @(posedge CLK);
        #2;
        check("mid_cs_before", EE_CS, 1'b1);
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_pins", {EE_CS, EE_SK, EE_DI}, 3'b000);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        rd(8'hC8, v); check("rst2_stat", v, 8'h01);
        rd(8'hC5, v); check("rst2_data", v, 8'h00);
        rd(8'hC6, v); check("rst2_cmd", v, 8'h00);
        repeat (10) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
